// File: rtl/sh7604_divu_ibus_master.sv
// Internal-bus master that drives one SH7604 DIVU division: writes divisor and dividend,
// reads back quotient, remainder and DVCR, and clears a pending overflow flag.
module sh7604_divu_ibus_master #(
    parameter logic [31:0] DIVU_BASE = 32'hFFFFFF00,
    parameter int unsigned MAX_WAIT  = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CE,
    input  logic        START,
    input  logic        DIV64,
    input  logic [31:0] DVSR_IN,
    input  logic [31:0] DVDNTH_IN,
    input  logic [31:0] DVDNTL_IN,
    output logic [31:0] QUOT,
    output logic [31:0] REM,
    output logic        OVF,
    output logic        ERR,
    output logic        DONE,
    output logic        ACTIVE,
    output logic [31:0] IBUS_A,
    output logic [31:0] IBUS_DO,
    input  logic [31:0] IBUS_DI,
    output logic [3:0]  IBUS_BA,
    output logic        IBUS_WE,
    output logic        IBUS_REQ,
    input  logic        IBUS_BUSY
);

    typedef enum logic [3:0] {
        StIdle,
        StWDvsr,
        StWDvdnth,
        StWDvdntl,
        StRQ,
        StRR,
        StRCr,
        StWCr,
        StFin
    } state_e;

    localparam logic [9:0] WAIT_LAST = 10'(MAX_WAIT - 1);

    state_e      state_q;
    state_e      next_acc;
    logic        div64_q;
    logic        ovfie_q;
    logic [31:0] dvsr_q;
    logic [31:0] dvdnth_q;
    logic [31:0] dvdntl_q;
    logic [9:0]  wait_q;
    logic [31:0] acc_addr;
    logic [31:0] acc_data;
    logic        acc_we;
    logic        acc_done;
    logic        acc_timeout;

    assign IBUS_BA = 4'hF;

    // The first cycle of an access never completes, even if the responder is not busy.
    assign acc_done    = IBUS_REQ && (wait_q != 10'd0) && !IBUS_BUSY;
    assign acc_timeout = IBUS_REQ && (wait_q == WAIT_LAST);

    always_comb begin
        acc_addr = '0;
        acc_data = '0;
        acc_we   = 1'b0;
        next_acc = StFin;
        case (state_q)
            StWDvsr: begin
                acc_addr = DIVU_BASE;
                acc_data = dvsr_q;
                acc_we   = 1'b1;
                next_acc = div64_q ? StWDvdnth : StWDvdntl;
            end
            StWDvdnth: begin
                acc_addr = DIVU_BASE + 32'h10;
                acc_data = dvdnth_q;
                acc_we   = 1'b1;
                next_acc = StWDvdntl;
            end
            StWDvdntl: begin
                acc_addr = DIVU_BASE + (div64_q ? 32'h14 : 32'h04);
                acc_data = dvdntl_q;
                acc_we   = 1'b1;
                next_acc = StRQ;
            end
            StRQ: begin
                acc_addr = DIVU_BASE + 32'h14;
                next_acc = StRR;
            end
            StRR: begin
                acc_addr = DIVU_BASE + 32'h10;
                next_acc = StRCr;
            end
            StRCr: begin
                acc_addr = DIVU_BASE + 32'h08;
                next_acc = IBUS_DI[0] ? StWCr : StFin;
            end
            StWCr: begin
                acc_addr = DIVU_BASE + 32'h08;
                acc_data = {30'b0, ovfie_q, 1'b0};
                acc_we   = 1'b1;
                next_acc = StFin;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= StIdle;
            div64_q  <= 1'b0;
            ovfie_q  <= 1'b0;
            dvsr_q   <= '0;
            dvdnth_q <= '0;
            dvdntl_q <= '0;
            wait_q   <= '0;
            QUOT     <= '0;
            REM      <= '0;
            OVF      <= 1'b0;
            ERR      <= 1'b0;
            DONE     <= 1'b0;
            ACTIVE   <= 1'b0;
            IBUS_REQ <= 1'b0;
            IBUS_WE  <= 1'b0;
            IBUS_A   <= '0;
            IBUS_DO  <= '0;
        end else if (CE) begin
            DONE <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (START) begin
                        div64_q  <= DIV64;
                        dvsr_q   <= DVSR_IN;
                        dvdnth_q <= DVDNTH_IN;
                        dvdntl_q <= DVDNTL_IN;
                        ACTIVE   <= 1'b1;
                        OVF      <= 1'b0;
                        ERR      <= 1'b0;
                        state_q  <= StWDvsr;
                    end
                end
                StFin: begin
                    DONE    <= 1'b1;
                    ACTIVE  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    // REQ low in an access state is the idle gap; the next CE edge launches.
                    if (!IBUS_REQ) begin
                        IBUS_REQ <= 1'b1;
                        IBUS_A   <= acc_addr;
                        IBUS_WE  <= acc_we;
                        IBUS_DO  <= acc_data;
                        wait_q   <= '0;
                    end else if (acc_done) begin
                        IBUS_REQ <= 1'b0;
                        IBUS_WE  <= 1'b0;
                        IBUS_A   <= '0;
                        IBUS_DO  <= '0;
                        state_q  <= next_acc;
                        case (state_q)
                            StRQ:    QUOT <= IBUS_DI;
                            StRR:    REM  <= IBUS_DI;
                            StRCr: begin
                                OVF     <= IBUS_DI[0];
                                ovfie_q <= IBUS_DI[1];
                            end
                            default: ;
                        endcase
                    end else if (acc_timeout) begin
                        IBUS_REQ <= 1'b0;
                        IBUS_WE  <= 1'b0;
                        IBUS_A   <= '0;
                        IBUS_DO  <= '0;
                        ERR      <= 1'b1;
                        state_q  <= StFin;
                    end else begin
                        wait_q <= wait_q + 10'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sh7604_divu_ibus_master.sv
// Randomised bench for sh7604_divu_ibus_master: a behavioural DIVU responder plus an
// arithmetic reference model of the expected access sequence and results.
module tb_sh7604_divu_ibus_master;

    localparam logic [31:0] BASE = 32'hFFFFFF00;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] data;
    } acc_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b0;
    logic        start = 1'b0;
    logic        start2 = 1'b0;
    logic        div64 = 1'b0;
    logic [31:0] dvsr = '0, dvdnth = '0, dvdntl = '0;
    logic [31:0] quot, rem, ibus_a, ibus_do;
    logic [31:0] ibus_di = '0;
    logic [3:0]  ibus_ba;
    logic        ovf, err, done, active, ibus_we, ibus_req;
    logic        ibus_busy = 1'b0;
    logic [31:0] quot2, rem2, a2, do2, di2;
    logic [3:0]  ba2;
    logic        ovf2, err2, done2, active2, we2, req2;
    logic        busy2 = 1'b0;

    int errors = 0;
    int checks = 0;

    // Responder / monitor state
    int          ce_mode = 2;  // 0: CE=1, 1: random CE, 2: CE=0
    int          busy_pct = 0;
    logic [31:0] stall_addr = '0;
    logic        stall_we = 1'b0;
    int          stall_left = 0;
    bit          ovfie_cfg = 1'b0;
    logic [31:0] r_dvsr = '0, r_q = '0, r_r = '0;
    bit          r_ovf = 1'b0;
    acc_t        log_q[$];
    int          age = 0, gap = 0, done_cnt = 0;
    bit          had_acc = 1'b0, done_prev = 1'b0;
    int          stab_viol = 0, gap_viol = 0, idle_viol = 0;
    acc_t        first_beat;

    sh7604_divu_ibus_master dut (
        .CLK(clk), .RST(rst), .CE(ce), .START(start), .DIV64(div64),
        .DVSR_IN(dvsr), .DVDNTH_IN(dvdnth), .DVDNTL_IN(dvdntl),
        .QUOT(quot), .REM(rem), .OVF(ovf), .ERR(err), .DONE(done), .ACTIVE(active),
        .IBUS_A(ibus_a), .IBUS_DO(ibus_do), .IBUS_DI(ibus_di), .IBUS_BA(ibus_ba),
        .IBUS_WE(ibus_we), .IBUS_REQ(ibus_req), .IBUS_BUSY(ibus_busy)
    );

    sh7604_divu_ibus_master #(.MAX_WAIT(4)) dut4 (
        .CLK(clk), .RST(rst), .CE(ce), .START(start2), .DIV64(div64),
        .DVSR_IN(dvsr), .DVDNTH_IN(dvdnth), .DVDNTL_IN(dvdntl),
        .QUOT(quot2), .REM(rem2), .OVF(ovf2), .ERR(err2), .DONE(done2), .ACTIVE(active2),
        .IBUS_A(a2), .IBUS_DO(do2), .IBUS_DI(di2), .IBUS_BA(ba2),
        .IBUS_WE(we2), .IBUS_REQ(req2), .IBUS_BUSY(busy2)
    );

    assign di2 = ~a2;

    always #5 clk = ~clk;

    // Signed DIVU arithmetic; on overflow the dividend registers are left as written.
    function automatic void divu_ref(input bit m64, input logic [31:0] d, h, l,
                                     output bit ov, output logic [31:0] q, r);
        longint dvd, dv, qq, rr;
        dvd = m64 ? $signed({h, l}) : $signed({{32{l[31]}}, l});
        dv  = $signed({{32{d[31]}}, d});
        ov  = 1'b0;
        q   = l;
        r   = m64 ? h : {32{l[31]}};
        if (dv == 0) ov = 1'b1;
        else if (dvd == 64'sh8000000000000000 && dv == -1) ov = 1'b1;
        else begin
            qq = dvd / dv;
            rr = dvd % dv;
            if (qq > 64'sd2147483647 || qq < -64'sd2147483648) ov = 1'b1;
            else begin
                q = qq[31:0];
                r = rr[31:0];
            end
        end
    endfunction

    // Responder: drives CE, BUSY and read data between the falling and rising edges.
    always begin
        @(negedge clk);
        #2;
        if (ce_mode == 2) ce = 1'b0;
        else if (ce_mode == 1 && !start && !start2) ce = ($urandom_range(0, 3) != 0);
        else ce = 1'b1;
        if (ibus_req && stall_left > 0 && ibus_a == stall_addr && ibus_we == stall_we) begin
            ibus_busy = 1'b1;
            if (ce) stall_left = stall_left - 1;
        end else begin
            ibus_busy = (busy_pct > 0) && ($urandom_range(0, 99) < busy_pct);
        end
        case (ibus_a - BASE)
            32'h00:  ibus_di = r_dvsr;
            32'h08:  ibus_di = {30'b0, ovfie_cfg, r_ovf};
            32'h10:  ibus_di = r_r;
            32'h14:  ibus_di = r_q;
            default: ibus_di = 32'hDEADBEEF;
        endcase
    end

    // Monitor: just before each rising edge, predicts what that edge does to the bus.
    always begin
        @(negedge clk);
        #3;
        if (!ibus_req && (ibus_a != '0 || ibus_we || ibus_do != '0)) idle_viol++;
        if (rst) begin
            age = 0;
            gap = 0;
            had_acc = 1'b0;
        end else if (ce) begin
            if (!ibus_req) begin
                gap++;
                age = 0;
            end else begin
                if (age == 0) begin
                    first_beat = '{addr: ibus_a, we: ibus_we, data: ibus_do};
                    if (had_acc && gap != 1) gap_viol++;
                end else if (ibus_a != first_beat.addr || ibus_we != first_beat.we
                             || ibus_do != first_beat.data) begin
                    stab_viol++;
                end
                if (age > 0 && !ibus_busy) begin
                    log_q.push_back('{addr: ibus_a, we: ibus_we,
                                      data: ibus_we ? ibus_do : ibus_di});
                    if (ibus_we) begin
                        case (ibus_a - BASE)
                            32'h00: r_dvsr = ibus_do;
                            32'h04: divu_ref(1'b0, r_dvsr, 32'h0, ibus_do, r_ovf, r_q, r_r);
                            32'h08: r_ovf = ibus_do[0];
                            32'h10: r_r = ibus_do;
                            32'h14: divu_ref(1'b1, r_dvsr, r_r, ibus_do, r_ovf, r_q, r_r);
                            default: ;
                        endcase
                    end
                    age = 0;
                    gap = 0;
                    had_acc = 1'b1;
                end else begin
                    age++;
                end
            end
        end
        if (done && !done_prev) done_cnt++;
        if (done) had_acc = 1'b0;
        done_prev = done;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic run_div(input bit m64, input logic [31:0] d, h, l, input bit ie,
                           input int cem, input int bp, input string tag);
        acc_t        exp_q[$];
        bit          e_ovf;
        logic [31:0] e_q, e_r;
        int          dc0;
        divu_ref(m64, d, h, l, e_ovf, e_q, e_r);
        exp_q.push_back('{addr: BASE, we: 1'b1, data: d});
        if (m64) begin
            exp_q.push_back('{addr: BASE + 32'h10, we: 1'b1, data: h});
            exp_q.push_back('{addr: BASE + 32'h14, we: 1'b1, data: l});
        end else begin
            exp_q.push_back('{addr: BASE + 32'h04, we: 1'b1, data: l});
        end
        exp_q.push_back('{addr: BASE + 32'h14, we: 1'b0, data: '0});
        exp_q.push_back('{addr: BASE + 32'h10, we: 1'b0, data: '0});
        exp_q.push_back('{addr: BASE + 32'h08, we: 1'b0, data: '0});
        if (e_ovf) exp_q.push_back('{addr: BASE + 32'h08, we: 1'b1, data: {30'b0, ie, 1'b0}});

        div64 = m64; dvsr = d; dvdnth = h; dvdntl = l;
        ovfie_cfg = ie; ce_mode = cem; busy_pct = bp;
        log_q.delete();
        dc0 = done_cnt;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        dvsr = $urandom; dvdnth = $urandom; dvdntl = $urandom; div64 = ~m64;
        checks++;
        if (active !== 1'b1) begin
            errors++;
            $display("FAIL %s active_after_start: got %b expected 1", tag, active);
        end
        for (int n = 0; n < 4000 && done_cnt == dc0; n++) cyc(1);
        cyc(4);
        ce_mode = 0;
        busy_pct = 0;
        checks++;
        if (done_cnt - dc0 != 1) begin
            errors++;
            $display("FAIL %s done_pulses: got %0d expected 1", tag, done_cnt - dc0);
        end
        checks++;
        if (log_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s access_count: got %0d expected %0d", tag, log_q.size(),
                     exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            checks++;
            if (log_q[i].addr !== exp_q[i].addr || log_q[i].we !== exp_q[i].we
                || (exp_q[i].we && log_q[i].data !== exp_q[i].data)) begin
                errors++;
                $display("FAIL %s access%0d: got a=%h we=%b d=%h expected a=%h we=%b d=%h",
                         tag, i, log_q[i].addr, log_q[i].we, log_q[i].data,
                         exp_q[i].addr, exp_q[i].we, exp_q[i].data);
            end
        end
        checks++;
        if (quot !== e_q || rem !== e_r || ovf !== e_ovf) begin
            errors++;
            $display("FAIL %s result: got q=%h r=%h ovf=%b expected q=%h r=%h ovf=%b",
                     tag, quot, rem, ovf, e_q, e_r, e_ovf);
        end
        checks++;
        if (err !== 1'b0 || active !== 1'b0 || ibus_req !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_flags: got err=%b active=%b req=%b expected 0 0 0",
                     tag, err, active, ibus_req);
        end
    endtask

    task automatic test_reset();
        ce_mode = 2;
        rst = 1'b1;
        cyc(3);
        checks++;
        if ({quot, rem} !== 64'h0 || {ovf, err, done, active} !== 4'h0) begin
            errors++;
            $display("FAIL reset_results: got q=%h r=%h flags=%b expected zeros", quot, rem,
                     {ovf, err, done, active});
        end
        checks++;
        if ({ibus_req, ibus_we} !== 2'b00 || ibus_a !== '0 || ibus_do !== '0
            || ibus_ba !== 4'hF) begin
            errors++;
            $display("FAIL reset_bus: got req=%b we=%b a=%h do=%h ba=%h expected 0 0 0 0 f",
                     ibus_req, ibus_we, ibus_a, ibus_do, ibus_ba);
        end
        rst = 1'b0;
        ce_mode = 0;
        cyc(2);
    endtask

    task automatic test_div32();
        run_div(1'b0, 32'd7, 32'h0, 32'd100, 1'b0, 0, 0, "div32");
        checks++;
        if (quot !== 32'd14 || rem !== 32'd2) begin
            errors++;
            $display("FAIL div32_const: got q=%0d r=%0d expected 14 2", quot, rem);
        end
    endtask

    task automatic test_div64_neg();
        run_div(1'b1, 32'hFFFFFFFD, 32'h0, 32'h10, 1'b0, 0, 0, "div64neg");
        checks++;
        if (quot !== 32'hFFFFFFFB || rem !== 32'd1 || log_q.size() != 6) begin
            errors++;
            $display("FAIL div64neg_const: got q=%h r=%h n=%0d expected fffffffb 1 6",
                     quot, rem, log_q.size());
        end
    endtask

    task automatic test_overflow();
        run_div(1'b0, 32'h0, 32'h0, 32'h1234, 1'b1, 0, 0, "ovf");
        checks++;
        if (ovf !== 1'b1 || log_q.size() == 0
            || log_q[log_q.size() - 1] !== '{addr: 32'hFFFFFF08, we: 1'b1, data: 32'h2}) begin
            errors++;
            $display("FAIL ovf_wcr: got ovf=%b n=%0d expected ovf=1 last write 2 to ffffff08",
                     ovf, log_q.size());
        end
    endtask

    task automatic test_busy_stall();
        stall_addr = BASE + 32'h14;
        stall_we = 1'b0;
        stall_left = 40;
        run_div(1'b0, 32'd3, 32'h0, 32'd1000, 1'b0, 0, 0, "stall");
        checks++;
        if (stall_left != 0 || stab_viol != 0) begin
            errors++;
            $display("FAIL stall_hold: got left=%0d unstable=%0d expected 0 0", stall_left,
                     stab_viol);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 14; i++) begin
            logic [31:0] d, h, l;
            bit          m;
            m = 1'($urandom_range(0, 1));
            l = $urandom;
            case ($urandom_range(0, 3))
                0:       d = 32'h0;
                1:       d = 32'($urandom_range(1, 20));
                2:       d = -32'($urandom_range(1, 20));
                default: d = $urandom;
            endcase
            h = $urandom_range(0, 1) ? {32{l[31]}} : 32'($urandom_range(0, 3));
            run_div(m, d, h, l, 1'($urandom_range(0, 1)), 1, 25, "random");
        end
    endtask

    task automatic test_protocol();
        checks++;
        if (stab_viol != 0 || gap_viol != 0 || idle_viol != 0) begin
            errors++;
            $display("FAIL protocol: got unstable=%0d gap=%0d idle=%0d expected 0 0 0",
                     stab_viol, gap_viol, idle_viol);
        end
    endtask

    task automatic test_reset_midflight();
        int dc0;
        bit seen = 1'b0;
        stall_addr = BASE + 32'h04;
        stall_we = 1'b1;
        stall_left = 1000;
        ce_mode = 0;
        log_q.delete();
        div64 = 1'b0; dvsr = 32'd5; dvdntl = 32'h55;
        start = 1'b1;
        cyc(1);
        dvsr = 32'd9; dvdntl = 32'h99;  // second START while busy must be ignored
        cyc(1);
        start = 1'b0;
        for (int n = 0; n < 60 && !seen; n++) begin
            cyc(1);
            seen = ibus_req && ibus_we && ibus_a == BASE + 32'h04;
        end
        checks++;
        if (!seen || ibus_do !== 32'h55 || log_q.size() != 1 || log_q[0].data !== 32'd5) begin
            errors++;
            $display("FAIL restart_ignored: got seen=%b do=%h n=%0d expected 1 55 1 (dvsr 5)",
                     seen, ibus_do, log_q.size());
        end
        rst = 1'b1;
        ce_mode = 2;
        cyc(1);
        checks++;
        if ({ibus_req, ibus_we, active, done, ovf, err} !== 6'b0 || ibus_a !== '0
            || ibus_do !== '0 || quot !== '0 || rem !== '0) begin
            errors++;
            $display("FAIL midreset: got req=%b we=%b act=%b a=%h do=%h q=%h expected zeros",
                     ibus_req, ibus_we, active, ibus_a, ibus_do, quot);
        end
        rst = 1'b0;
        ce_mode = 0;
        stall_left = 0;
        dc0 = done_cnt;
        cyc(30);
        checks++;
        if (done_cnt != dc0 || active !== 1'b0 || ibus_req !== 1'b0 || log_q.size() != 1) begin
            errors++;
            $display("FAIL no_resume: got dones=%0d act=%b req=%b n=%0d expected 0 0 0 1",
                     done_cnt - dc0, active, ibus_req, log_q.size());
        end
    endtask

    task automatic test_timeout();
        int  nreq = 0;
        bit  seen = 1'b0;
        bit  err_at_drop = 1'b0;
        busy2 = 1'b0;
        ce_mode = 0;
        start2 = 1'b1;
        cyc(1);
        start2 = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
            cyc(1);
            seen = done2;
        end
        checks++;
        if (!seen || quot2 !== ~(BASE + 32'h14) || rem2 !== ~(BASE + 32'h10) || err2 !== 1'b0) begin
            errors++;
            $display("FAIL to_prior: got done=%b q=%h r=%h err=%b expected 1 %h %h 0", seen,
                     quot2, rem2, err2, ~(BASE + 32'h14), ~(BASE + 32'h10));
        end
        cyc(2);
        busy2 = 1'b1;
        start2 = 1'b1;
        cyc(1);
        start2 = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            cyc(1);
            if (req2) nreq++;
            else if (nreq > 0) begin
                seen = 1'b1;
                err_at_drop = err2;
            end
        end
        checks++;
        if (!seen || nreq != 4 || err_at_drop !== 1'b1) begin
            errors++;
            $display("FAIL to_abort: got dropped=%b cycles=%0d err=%b expected 1 4 1", seen,
                     nreq, err_at_drop);
        end
        seen = 1'b0;
        for (int n = 0; n < 5 && !seen; n++) begin
            seen = done2;
            if (!seen) cyc(1);
        end
        checks++;
        if (!seen || quot2 !== ~(BASE + 32'h14) || rem2 !== ~(BASE + 32'h10)) begin
            errors++;
            $display("FAIL to_done: got done=%b q=%h r=%h expected 1 %h %h", seen, quot2, rem2,
                     ~(BASE + 32'h14), ~(BASE + 32'h10));
        end
        cyc(1);
        checks++;
        if (active2 !== 1'b0 || err2 !== 1'b1 || req2 !== 1'b0) begin
            errors++;
            $display("FAIL to_final: got act=%b err=%b req=%b expected 0 1 0", active2, err2,
                     req2);
        end
        busy2 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_div32();
        test_div64_neg();
        test_overflow();
        test_busy_stall();
        test_random();
        test_protocol();
        test_reset_midflight();
        test_timeout();
        test_protocol();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
